if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage that directly drives the instruction ROM's chip-enable and address inputs.
- The ROM is combinational: the instruction comes back in the same cycle the address is presented.
- The stage owns the PC register and captures PC/instruction pairs into the IF/ID pipeline register, using a valid/ready handshake towards decode.
- It also handles branch redirects from downstream and raises a fetch-misalignment exception.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_ce_o  out  1  ROM chip enable; `ChipEnable or `ChipDisable.
- rom_addr_o  out  32 (`InstAddrBus)  byte address to the ROM; the ROM word-indexes with addr[..:2].
- rom_inst_i  in  32 (`InstBus)  instruction returned by the ROM in the same cycle.
- id_ready_i  in  1  decode can accept an IF/ID entry this cycle.
- if_valid_o  out  1  IF/ID entry is valid.
- if_pc_o  out  32  PC of the IF/ID entry.
- if_inst_o  out  32  instruction of the IF/ID entry.
- redirect_i  in  1  branch/jump taken; flush and redirect.
- redirect_pc_i  in  32  redirect target.
- excp_o  out  1  misaligned-fetch exception pending.
- excp_pc_o  out  32  faulting target address.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc_q=RESET_PC.
  - rom_ce_o=`ChipDisable, rom_addr_o=0.
  - if_valid_o=0, if_pc_o=0, if_inst_o=`ZeroWord.
  - excp_o=0, excp_pc_o=0.
- rom_ce_o is registered: it is `ChipEnable exactly when state=RUN.
- rom_addr_o = pc_q when state=RUN, else 0. It is combinational from registers, with no path from any input.
- FSM states: IDLE, RUN, FAULT.
  - IDLE: on the first rising edge after reset release, go to RUN. No fetch occurs while in IDLE.
  - RUN: on each edge, apply the first matching rule:
    - (a) redirect_i=1 and redirect_pc_i[1:0]==0: pc_q<=redirect_pc_i; if_valid_o<=0. The instruction currently at the ROM is discarded.
    - (b) redirect_i=1 and redirect_pc_i[1:0]!=0: state<=FAULT; excp_o<=1; excp_pc_o<=redirect_pc_i; if_valid_o<=0.
    - (c) capture, when if_valid_o==0 or id_ready_i==1: if_pc_o<=pc_q; if_inst_o<=rom_inst_i; if_valid_o<=1; pc_q<=pc_q+PC_STEP.
    - (d) otherwise (stall): pc_q, if_pc_o, if_inst_o and if_valid_o all hold.
  - FAULT: rom_ce_o disabled, if_valid_o=0, excp_o held at 1.
    - Leave FAULT only on redirect_i=1 with an aligned target: state<=RUN, pc_q<=target, excp_o<=0.
    - A misaligned redirect while in FAULT updates excp_pc_o and stays in FAULT.
- Timing and throughput:
  - Fetch-to-IF/ID latency is 1 cycle.
  - With id_ready_i held at 1, throughput is one instruction per cycle.
  - The first valid entry appears 2 edges after reset release.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- A redirect outranks a stall: a held entry is dropped even if id_ready_i=0.
- An entry accepted by decode in the same cycle as a redirect counts as consumed; the flush affects only the next entry.
- if_inst_o is `ZeroWord whenever if_valid_o=0 after a flush or reset. A stalled entry keeps its contents.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- With it defined:
  - Adds two 32-bit outputs, perf_fetch_o and perf_flush_o, each reset to 0.
  - perf_fetch_o increments on every capture (rule c).
  - perf_flush_o increments on every redirect in RUN (rules a and b).
  - Both counters saturate at 32'hFFFF_FFFF.
- Without it: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- In define.v: the state encodings `FetchIdle/`FetchRun/`FetchFault (2 bits) and `PcStep. The existing `ChipEnable/`ChipDisable, `ZeroWord, `InstAddrBus and `InstBus are reused.
- One sub-module, if_id_reg, holds the IF/ID register. It takes load/flush/hold controls and outputs valid/pc/inst.
- if_fetch keeps the FSM and pc_q.

Test Plan:
- Reset, then release with id_ready_i=1 and the ROM returning word index+1 → rom_ce_o enabled after 1 edge; if_pc_o = 0,4,8 with if_inst_o = 1,2,3 on consecutive cycles; if_valid_o first 1 on the 2nd edge.
- Stall: hold id_ready_i=0 for 3 cycles while if_pc_o=8 → if_pc_o, if_inst_o and rom_addr_o stay constant (rom_addr_o=12); on release the next entry is pc=12.
- Redirect to 0x100 while id_ready_i=0 → next edge if_valid_o=0, rom_addr_o=0x100; the following edge gives if_pc_o=0x100.
- Redirect to 0x102 → excp_o=1, excp_pc_o=0x102, rom_ce_o disabled, if_valid_o=0. A later redirect to 0x200 clears excp_o and resumes fetch at 0x200.
- Set RESET_PC=32'hFFFF_FFF8 → entries at 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0.
- Assert rst mid-stream → all outputs clear immediately without a clock edge; fetch restarts at RESET_PC. With IF_FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by the top: IF_FETCH_PERF_EN.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic              CHIP_ENABLE  = 1'b1;
    localparam logic              CHIP_DISABLE = 1'b0;
    localparam logic [INST_W-1:0] ZERO_WORD    = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    function automatic logic is_aligned(input logic [INST_ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    // Saturating increment for the event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register: load captures a PC/instruction pair, flush empties it
// (contents zeroed), neither holds the current entry.
module if_id_reg
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] pc_in,
    input  logic [INST_W-1:0]      inst_in,
    output logic                   valid,
    output logic [INST_ADDR_W-1:0] pc,
    output logic [INST_W-1:0]      inst
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= ZERO_WORD;
        end else if (flush) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= ZERO_WORD;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            inst  <= inst_in;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a combinational ROM, fills the IF/ID
// register and raises a misaligned-redirect exception. Define IF_FETCH_PERF_EN for counters.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0]      rom_inst_i,
    input  logic                   id_ready_i,
    output logic                   if_valid_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    input  logic                   redirect_i,
    input  logic [INST_ADDR_W-1:0] redirect_pc_i,
    output logic                   excp_o,
    output logic [INST_ADDR_W-1:0] excp_pc_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetch_o,
    output logic [31:0]            perf_flush_o
`endif
);

    localparam logic [INST_ADDR_W-1:0] PC_INC = INST_ADDR_W'(PC_STEP);

    fetch_state_e           state_reg, state_next;
    logic [INST_ADDR_W-1:0] pc_reg, pc_next;
    logic                   excp_reg, excp_next;
    logic [INST_ADDR_W-1:0] excp_pc_reg, excp_pc_next;
    logic                   rom_ce_reg;
    logic                   load, flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= FETCH_IDLE;
            pc_reg      <= RESET_PC;
            excp_reg    <= 1'b0;
            excp_pc_reg <= '0;
            rom_ce_reg  <= CHIP_DISABLE;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            excp_reg    <= excp_next;
            excp_pc_reg <= excp_pc_next;
            rom_ce_reg  <= (state_next == FETCH_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
        end
    end

    // Redirect outranks capture, which outranks stall.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        excp_next    = excp_reg;
        excp_pc_next = excp_pc_reg;
        load         = 1'b0;
        flush        = 1'b0;
        case (state_reg)
            FETCH_IDLE: begin
                state_next = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (redirect_i) begin
                    flush = 1'b1;
                    if (is_aligned(redirect_pc_i)) begin
                        pc_next = redirect_pc_i;
                    end else begin
                        state_next   = FETCH_FAULT;
                        excp_next    = 1'b1;
                        excp_pc_next = redirect_pc_i;
                    end
                end else if (!if_valid_o || id_ready_i) begin
                    load    = 1'b1;
                    pc_next = pc_reg + PC_INC;
                end
            end
            FETCH_FAULT: begin
                if (redirect_i) begin
                    if (is_aligned(redirect_pc_i)) begin
                        state_next = FETCH_RUN;
                        pc_next    = redirect_pc_i;
                        excp_next  = 1'b0;
                    end else begin
                        excp_pc_next = redirect_pc_i;
                    end
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    assign rom_ce_o   = rom_ce_reg;
    assign rom_addr_o = (state_reg == FETCH_RUN) ? pc_reg : '0;
    assign excp_o     = excp_reg;
    assign excp_pc_o  = excp_pc_reg;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .flush   (flush),
        .pc_in   (pc_reg),
        .inst_in (rom_inst_i),
        .valid   (if_valid_o),
        .pc      (if_pc_o),
        .inst    (if_inst_o)
    );

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_reg, perf_flush_reg;

    // flush is only raised by a redirect seen in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (load)  perf_fetch_reg <= sat_inc(perf_fetch_reg);
            if (flush) perf_flush_reg <= sat_inc(perf_flush_reg);
        end
    end

    assign perf_fetch_o = perf_fetch_reg;
    assign perf_flush_o = perf_flush_reg;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a vector table for the main fetch/stall/redirect/fault
// flow, plus sequences for asynchronous reset and PC wrap-around.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        rom_ce, if_valid, excp;
    logic [31:0] rom_addr, rom_inst, if_pc, if_inst, excp_pc;

    logic        rom_ce2, if_valid2, excp2;
    logic [31:0] rom_addr2, rom_inst2, if_pc2, if_inst2, excp_pc2;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_flush, perf_fetch2, perf_flush2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // ROM returns word index + 1.
    assign rom_inst  = (rom_addr  >> 2) + 32'd1;
    assign rom_inst2 = (rom_addr2 >> 2) + 32'd1;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce_o      (rom_ce),
        .rom_addr_o    (rom_addr),
        .rom_inst_i    (rom_inst),
        .id_ready_i    (id_ready),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_inst_o     (if_inst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .excp_o        (excp),
        .excp_pc_o     (excp_pc)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_o  (perf_fetch),
        .perf_flush_o  (perf_flush)
`endif
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .rom_ce_o      (rom_ce2),
        .rom_addr_o    (rom_addr2),
        .rom_inst_i    (rom_inst2),
        .id_ready_i    (1'b1),
        .if_valid_o    (if_valid2),
        .if_pc_o       (if_pc2),
        .if_inst_o     (if_inst2),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .excp_o        (excp2),
        .excp_pc_o     (excp_pc2)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_o  (perf_fetch2),
        .perf_flush_o  (perf_flush2)
`endif
    );

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        ce;
        logic        ex;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int row, input vec_t e);
        chk("if_valid", row, {31'd0, if_valid}, {31'd0, e.v});
        chk("if_pc", row, if_pc, e.pc);
        chk("if_inst", row, if_inst, e.inst);
        chk("rom_addr", row, rom_addr, e.addr);
        chk("rom_ce", row, {31'd0, rom_ce}, {31'd0, e.ce});
        chk("excp", row, {31'd0, excp}, {31'd0, e.ex});
        chk("excp_pc", row, excp_pc, e.epc);
        $display("row %2d: rd=%0b rpc=%h rdy=%0b -> v=%0b pc=%h inst=%h addr=%h ce=%0b ex=%0b epc=%h",
                 row, e.redirect, e.rpc, e.ready, if_valid, if_pc, if_inst, rom_addr,
                 rom_ce, excp, excp_pc);
    endtask

    initial begin
        //          rd    rpc           rdy   v     pc            inst          addr          ce    ex    epc
        tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h1,        32'h4,        1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h2,        32'h8,        1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h3,        32'hC,        1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h3,        32'hC,        1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h3,        32'hC,        1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h3,        32'hC,        1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h4,        32'h10,       1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        32'h0,        32'h100,      1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      32'h41,       32'h104,      1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 32'h102,      1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 32'h102};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 32'h102};
        tbl[12] = '{1'b1, 32'h203,      1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 32'h203};
        tbl[13] = '{1'b1, 32'h200,      1'b1, 1'b0, 32'h0,        32'h0,        32'h200,      1'b1, 1'b0, 32'h203};
        tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h81,       32'h204,      1'b1, 1'b0, 32'h203};

        // Reset state while rst is held low.
        #2;
        chk("rst_valid", -1, {31'd0, if_valid}, 32'd0);
        chk("rst_ce", -1, {31'd0, rom_ce}, 32'd0);
        chk("rst_addr", -1, rom_addr, 32'd0);
        chk("rst_inst", -1, if_inst, 32'd0);
        chk("rst_excp", -1, {31'd0, excp}, 32'd0);
        #10;
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            redirect    = tbl[i].redirect;
            redirect_pc = tbl[i].rpc;
            id_ready    = tbl[i].ready;
            step();
            chk_all(i, tbl[i]);
        end
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;

`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch", 15, perf_fetch, 32'd6);
        chk("perf_flush", 15, perf_flush, 32'd2);
`endif

        // Asynchronous reset mid-cycle: outputs clear without an edge.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 16, {31'd0, if_valid}, 32'd0);
        chk("arst_pc", 16, if_pc, 32'd0);
        chk("arst_inst", 16, if_inst, 32'd0);
        chk("arst_ce", 16, {31'd0, rom_ce}, 32'd0);
        chk("arst_addr", 16, rom_addr, 32'd0);
        chk("arst_excp", 16, {31'd0, excp}, 32'd0);
        chk("arst_excp_pc", 16, excp_pc, 32'd0);
`ifdef IF_FETCH_PERF_EN
        chk("arst_perf_fetch", 16, perf_fetch, 32'd0);
        chk("arst_perf_flush", 16, perf_flush, 32'd0);
`endif
        $display("async reset: v=%0b ce=%0b addr=%h ex=%0b", if_valid, rom_ce, rom_addr, excp);
        rst = 1'b1;

        // Restart at RESET_PC, and the second instance wraps through 0xFFFF_FFFC.
        step();
        chk("rs_ce", 17, {31'd0, rom_ce}, 32'd1);
        chk("rs_valid", 17, {31'd0, if_valid}, 32'd0);
        chk("wrap_addr", 17, rom_addr2, 32'hFFFF_FFF8);
        step();
        chk("rs_pc", 18, if_pc, 32'd0);
        chk("rs_inst", 18, if_inst, 32'd1);
        chk("wrap_pc", 18, if_pc2, 32'hFFFF_FFF8);
        chk("wrap_inst", 18, if_inst2, 32'h3FFF_FFFF);
        $display("restart: pc=%h inst=%h | wrap pc=%h inst=%h", if_pc, if_inst, if_pc2, if_inst2);
        step();
        chk("wrap_pc", 19, if_pc2, 32'hFFFF_FFFC);
        chk("wrap_inst", 19, if_inst2, 32'h4000_0000);
        $display("wrap: pc=%h inst=%h", if_pc2, if_inst2);
        step();
        chk("wrap_pc", 20, if_pc2, 32'h0);
        chk("wrap_inst", 20, if_inst2, 32'h1);
        chk("wrap_valid", 20, {31'd0, if_valid2}, 32'd1);
        chk("wrap_excp", 20, {31'd0, excp2}, 32'd0);
        $display("wrap: pc=%h inst=%h", if_pc2, if_inst2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
